// File: rtl/alu_pkg.sv
// ALU op codes and RV32I decode constants.
// Shared between the issue stage and the ALU.
package alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'b00000,
        ALU_SLL  = 5'b00001,
        ALU_SLT  = 5'b00010,
        ALU_SLTU = 5'b00011,
        ALU_XOR  = 5'b00100,
        ALU_SRL  = 5'b00101,
        ALU_OR   = 5'b00110,
        ALU_AND  = 5'b00111,
        ALU_SUB  = 5'b01000,
        ALU_SRA  = 5'b01101,
        ALU_BEQ  = 5'b10000,
        ALU_BNE  = 5'b10001,
        ALU_BLT  = 5'b10100,
        ALU_BGE  = 5'b10101,
        ALU_BLTU = 5'b10110,
        ALU_BGEU = 5'b10111,
        ALU_PASS = 5'b11111
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_BR2  = 3'b010;
    localparam logic [2:0] F3_BR3  = 3'b011;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [31:0] i;
        logic [31:0] s;
        logic [31:0] b;
        logic [31:0] u;
        logic [31:0] j;
    } imm_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Issue-stage handshake bundle: upstream instruction in,
// decoded ALU bundle out.
interface alu_issue_stage_if
    import alu_pkg::*;
#(
    parameter int CNT_W = 32
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      instr_i;
    logic [31:0]      pc_i;
    logic [31:0]      rs1_data_i;
    logic [31:0]      rs2_data_i;
    logic             flush_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [31:0]      alu_a_o;
    logic [31:0]      alu_b_o;
    alu_op_e          alu_op_o;
    logic [4:0]       rd_o;
    logic             reg_we_o;
    logic             is_branch_o;
    logic             is_jump_o;
    logic [31:0]      target_o;
    logic             illegal_o;
    logic [CNT_W-1:0] issued_cnt_o;

    modport master (
        input  in_valid_i, instr_i, pc_i, rs1_data_i, rs2_data_i,
        input  flush_i, out_ready_i,
        output in_ready_o, out_valid_o, alu_a_o, alu_b_o, alu_op_o,
        output rd_o, reg_we_o, is_branch_o, is_jump_o, target_o,
        output illegal_o, issued_cnt_o
    );

    modport slave (
        output in_valid_i, instr_i, pc_i, rs1_data_i, rs2_data_i,
        output flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, alu_a_o, alu_b_o, alu_op_o,
        input  rd_o, reg_we_o, is_branch_o, is_jump_o, target_o,
        input  illegal_o, issued_cnt_o
    );

endinterface

// File: rtl/alu_issue_stage_imm_gen.sv
// RV32I immediate extraction: I/S/B/U/J formats,
// each sign-extended to 32 bits.
module imm_gen
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output imm_t        imm
);

    always_comb begin
        imm.i = {{20{instr[31]}}, instr[31:20]};
        imm.s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        imm.b = {{19{instr[31]}}, instr[31], instr[7],
                 instr[30:25], instr[11:8], 1'b0};
        imm.u = {instr[31:12], 12'b0};
        imm.j = {{11{instr[31]}}, instr[31], instr[19:12],
                 instr[20], instr[30:21], 1'b0};
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Register-read to execute issue stage: decodes one RV32I
// instruction into ALU operands, op and control, one-entry buffered.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
)(
    input logic              clk_i,
    input logic              rst_ni,
    alu_issue_stage_if.master bus
);

    imm_t        imm;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;

    logic [XLEN-1:0] d_a, d_b, d_tgt;
    alu_op_e         d_op;
    logic            d_we, d_br, d_jmp, d_ill;

    logic            valid_q;
    logic            accept, handoff;

    imm_gen u_imm_gen (
        .instr (bus.instr_i),
        .imm   (imm)
    );

    assign opc = bus.instr_i[6:0];
    assign rd  = bus.instr_i[11:7];
    assign f3  = bus.instr_i[14:12];
    assign f7  = bus.instr_i[31:25];

    always_comb begin
        d_a   = '0;
        d_b   = '0;
        d_op  = ALU_ADD;
        d_we  = 1'b0;
        d_br  = 1'b0;
        d_jmp = 1'b0;
        d_tgt = '0;
        d_ill = 1'b0;
        unique case (opc)
            OPC_OP: begin
                d_a  = bus.rs1_data_i;
                d_b  = bus.rs2_data_i;
                d_op = alu_op_e'({1'b0, f7[5], f3});
                d_we = 1'b1;
                d_ill = !(f7 == F7_ZERO ||
                          (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)));
            end
            OPC_OP_IMM: begin
                d_a  = bus.rs1_data_i;
                d_we = 1'b1;
                if (f3 == F3_SLL || f3 == F3_SR) begin
                    d_b   = {27'b0, bus.instr_i[24:20]};
                    d_op  = alu_op_e'({1'b0, f7[5], f3});
                    d_ill = !(f7 == F7_ZERO ||
                              (f7 == F7_ALT && f3 == F3_SR));
                end else begin
                    d_b  = imm.i;
                    d_op = alu_op_e'({2'b00, f3});
                end
            end
            OPC_LUI: begin
                d_b  = imm.u;
                d_we = 1'b1;
            end
            OPC_AUIPC: begin
                d_a  = bus.pc_i;
                d_b  = imm.u;
                d_we = 1'b1;
            end
            OPC_BRANCH: begin
                d_a   = bus.rs1_data_i;
                d_b   = bus.rs2_data_i;
                d_op  = alu_op_e'({2'b10, f3});
                d_br  = 1'b1;
                d_tgt = bus.pc_i + imm.b;
                d_ill = (f3 == F3_BR2 || f3 == F3_BR3);
            end
            OPC_JAL: begin
                d_a   = bus.pc_i + 32'd4;
                d_op  = ALU_PASS;
                d_we  = 1'b1;
                d_jmp = 1'b1;
                d_tgt = bus.pc_i + imm.j;
            end
            OPC_JALR: begin
                d_a   = bus.pc_i + 32'd4;
                d_op  = ALU_PASS;
                d_we  = 1'b1;
                d_jmp = 1'b1;
                d_tgt = (bus.rs1_data_i + imm.i) & ~32'h1;
                d_ill = (f3 != F3_ADD);
            end
            default: d_ill = 1'b1;
        endcase
        // Illegal instructions issue as an inert ADD 0,0
        if (d_ill) begin
            d_a   = '0;
            d_b   = '0;
            d_op  = ALU_ADD;
            d_we  = 1'b0;
            d_br  = 1'b0;
            d_jmp = 1'b0;
            d_tgt = '0;
        end
        if (rd == 5'd0) d_we = 1'b0;
    end

    assign bus.in_ready_o = ~valid_q | bus.out_ready_i;
    assign accept  = bus.in_valid_i & bus.in_ready_o & ~bus.flush_i;
    assign handoff = valid_q & bus.out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q          <= 1'b0;
            bus.alu_a_o      <= '0;
            bus.alu_b_o      <= '0;
            bus.alu_op_o     <= ALU_ADD;
            bus.rd_o         <= '0;
            bus.reg_we_o     <= 1'b0;
            bus.is_branch_o  <= 1'b0;
            bus.is_jump_o    <= 1'b0;
            bus.target_o     <= '0;
            bus.illegal_o    <= 1'b0;
            bus.issued_cnt_o <= '0;
        end else begin
            if (bus.flush_i)  valid_q <= 1'b0;
            else if (accept)  valid_q <= 1'b1;
            else if (handoff) valid_q <= 1'b0;
            if (accept) begin
                bus.alu_a_o     <= d_a;
                bus.alu_b_o     <= d_b;
                bus.alu_op_o    <= d_op;
                bus.rd_o        <= rd;
                bus.reg_we_o    <= d_we;
                bus.is_branch_o <= d_br;
                bus.is_jump_o   <= d_jmp;
                bus.target_o    <= d_tgt;
                bus.illegal_o   <= d_ill;
            end
            if (handoff) bus.issued_cnt_o <= bus.issued_cnt_o + 1'b1;
        end
    end

    assign bus.out_valid_o = valid_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed-vector bench for alu_issue_stage.
// Inputs change 1ns after posedge; outputs checked there too.
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic [31:0] exp_cnt = 0;

    alu_issue_stage_if #(.CNT_W(32)) bus ();

    alu_issue_stage #(.XLEN(32), .CNT_W(32)) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (bus.master)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins,
                         input logic [31:0] pc, input logic [31:0] r1,
                         input logic [31:0] r2, input logic rdy,
                         input logic fl);
        bus.in_valid_i  = v;
        bus.instr_i     = ins;
        bus.pc_i        = pc;
        bus.rs1_data_i  = r1;
        bus.rs2_data_i  = r2;
        bus.out_ready_i = rdy;
        bus.flush_i     = fl;
    endtask

    initial begin
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        step();
        rst_ni = 1'b1;
        step();
        check("rst_valid", {31'b0, bus.out_valid_o}, 32'd0);
        check("rst_op",    {27'b0, bus.alu_op_o}, 32'd0);
        check("rst_ready", {31'b0, bus.in_ready_o}, 32'd1);
        check("rst_cnt",   bus.issued_cnt_o, 32'd0);

        // ADDI x5,x1,-1
        drive(1'b1, 32'hFFF08293, 32'h0, 32'd7, 32'd0, 1'b1, 1'b0);
        step();
        check("addi_valid", {31'b0, bus.out_valid_o}, 32'd1);
        check("addi_a",  bus.alu_a_o, 32'd7);
        check("addi_b",  bus.alu_b_o, 32'hFFFFFFFF);
        check("addi_op", {27'b0, bus.alu_op_o}, 32'd0);
        check("addi_rd", {27'b0, bus.rd_o}, 32'd5);
        check("addi_we", {31'b0, bus.reg_we_o}, 32'd1);
        check("addi_ill", {31'b0, bus.illegal_o}, 32'd0);

        // BLTU x1,x2,-8 at 0x100, back to back with ADDI handoff
        drive(1'b1, 32'hFE20ECE3, 32'h100, 32'd1, 32'd2, 1'b1, 1'b0);
        step();
        exp_cnt = 1;
        check("bltu_valid", {31'b0, bus.out_valid_o}, 32'd1);
        check("bltu_cnt", bus.issued_cnt_o, exp_cnt);
        check("bltu_op", {27'b0, bus.alu_op_o}, 32'b10110);
        check("bltu_a",  bus.alu_a_o, 32'd1);
        check("bltu_b",  bus.alu_b_o, 32'd2);
        check("bltu_br", {31'b0, bus.is_branch_o}, 32'd1);
        check("bltu_we", {31'b0, bus.reg_we_o}, 32'd0);
        check("bltu_tgt", bus.target_o, 32'h000000F8);

        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        exp_cnt = 2;
        check("idle_valid", {31'b0, bus.out_valid_o}, 32'd0);
        check("idle_cnt", bus.issued_cnt_o, exp_cnt);

        // ADD x3,x1,x2 then 3 stalled cycles with changing inputs
        drive(1'b1, 32'h002081B3, 32'h0, 32'd10, 32'd20, 1'b0, 1'b0);
        step();
        check("stall_valid0", {31'b0, bus.out_valid_o}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hFFF08293, 32'h40, 32'd99, 32'd98, 1'b0, 1'b0);
            check("stall_rdy", {31'b0, bus.in_ready_o}, 32'd0);
            step();
            check("stall_valid", {31'b0, bus.out_valid_o}, 32'd1);
            check("stall_a", bus.alu_a_o, 32'd10);
            check("stall_b", bus.alu_b_o, 32'd20);
            check("stall_rd", {27'b0, bus.rd_o}, 32'd3);
            check("stall_op", {27'b0, bus.alu_op_o}, 32'd0);
            check("stall_cnt", bus.issued_cnt_o, exp_cnt);
        end
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        exp_cnt = 3;
        check("stall_release", {31'b0, bus.out_valid_o}, 32'd0);
        check("stall_cnt_inc", bus.issued_cnt_o, exp_cnt);

        // Accept attempted in the flush cycle is dropped
        drive(1'b1, 32'hFFF08293, 32'h0, 32'd7, 32'd0, 1'b1, 1'b1);
        step();
        check("flush_valid", {31'b0, bus.out_valid_o}, 32'd0);
        check("flush_cnt", bus.issued_cnt_o, exp_cnt);

        // Flush kills a stalled bundle without counting it
        drive(1'b1, 32'h002081B3, 32'h0, 32'd1, 32'd2, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'h002081B3, 32'h0, 32'd1, 32'd2, 1'b0, 1'b1);
        step();
        check("flush_kill", {31'b0, bus.out_valid_o}, 32'd0);
        check("flush_kill_cnt", bus.issued_cnt_o, exp_cnt);

        // SLLI with funct7=0100000 is illegal
        drive(1'b1, 32'h40311093, 32'h0, 32'd5, 32'd6, 1'b1, 1'b0);
        step();
        check("slli_ill", {31'b0, bus.illegal_o}, 32'd1);
        check("slli_we", {31'b0, bus.reg_we_o}, 32'd0);
        check("slli_a", bus.alu_a_o, 32'd0);
        check("slli_b", bus.alu_b_o, 32'd0);

        // ADD x0,x1,x2: legal but no writeback
        drive(1'b1, 32'h00208033, 32'h0, 32'd5, 32'd6, 1'b1, 1'b0);
        step();
        exp_cnt = 4;
        check("addx0_ill", {31'b0, bus.illegal_o}, 32'd0);
        check("addx0_we", {31'b0, bus.reg_we_o}, 32'd0);
        check("addx0_b", bus.alu_b_o, 32'd6);
        check("addx0_cnt", bus.issued_cnt_o, exp_cnt);

        // JAL x1,+8 at 0x200
        drive(1'b1, 32'h008000EF, 32'h200, 32'd0, 32'd0, 1'b1, 1'b0);
        step();
        exp_cnt = 5;
        check("jal_a", bus.alu_a_o, 32'h204);
        check("jal_b", bus.alu_b_o, 32'd0);
        check("jal_op", {27'b0, bus.alu_op_o}, 32'b11111);
        check("jal_jmp", {31'b0, bus.is_jump_o}, 32'd1);
        check("jal_tgt", bus.target_o, 32'h208);
        check("jal_we", {31'b0, bus.reg_we_o}, 32'd1);

        // LUI x2,0x12345
        drive(1'b1, 32'h12345137, 32'h0, 32'd3, 32'd0, 1'b1, 1'b0);
        step();
        exp_cnt = 6;
        check("lui_a", bus.alu_a_o, 32'd0);
        check("lui_b", bus.alu_b_o, 32'h12345000);
        check("lui_jmp", {31'b0, bus.is_jump_o}, 32'd0);

        // Load opcode is unsupported
        drive(1'b1, 32'h0000A083, 32'h0, 32'd3, 32'd0, 1'b1, 1'b0);
        step();
        exp_cnt = 7;
        check("load_ill", {31'b0, bus.illegal_o}, 32'd1);
        check("load_we", {31'b0, bus.reg_we_o}, 32'd0);
        check("load_a", bus.alu_a_o, 32'd0);

        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        exp_cnt = 8;
        check("final_cnt", bus.issued_cnt_o, exp_cnt);
        check("final_valid", {31'b0, bus.out_valid_o}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
